bouncing_sprite_engine: RTL and testbench

- Multi-sprite successor to the single bouncing-square generator.
- Animates N_SPR independently bouncing square sprites over a background, one position update per frame.
- Sits between the VGA timing generator (i_x, i_y, i_video_on) and the RGB output pins.
- Adds the following to the single-sprite version:
  - registered pixel output;
  - clamped edge reflection (sprites never leave the screen);
  - pause and speed control;
  - a per-sprite bounce event output.

---
 rtl/bouncing_sprite_engine.sv | 128 ++++++++++++
 tb/tb_bouncing_sprite_engine.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bouncing_sprite_engine.sv
// Animates N_SPR square sprites that bounce inside the visible area and
// composites them over a background colour with a registered pixel output.
module bouncing_sprite_engine #(
    parameter int          N_SPR    = 4,
    parameter int          SPR_SIZE = 32,
    parameter logic [95:0] SPR_RGB  = {48'h0, 12'hFF0, 12'h00F, 12'h0F0, 12'hF00},
    parameter logic [11:0] BG_RGB   = 12'h000,
    parameter int          X_MAX    = 639,
    parameter int          Y_MAX    = 479,
    parameter int          TICK_Y   = 481,
    parameter int          VEL_MAX  = 7
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_video_on,
    input  logic [9:0]       i_x,
    input  logic [9:0]       i_y,
    input  logic             i_pause,
    input  logic [2:0]       i_speed,
    output logic [11:0]      o_rgb,
    output logic             o_frame_tick,
    output logic [N_SPR-1:0] o_bounce
);

    localparam int             PW       = 11;
    localparam logic [PW-1:0]  X_LIM    = PW'(X_MAX - SPR_SIZE + 1);
    localparam logic [PW-1:0]  Y_LIM    = PW'(Y_MAX - SPR_SIZE + 1);
    localparam logic [PW-1:0]  SPR_LAST = PW'(SPR_SIZE - 1);
    localparam logic [PW-1:0]  V_CAP    = PW'(VEL_MAX);
    localparam logic [9:0]     TICK_ROW = 10'(TICK_Y);

    logic [N_SPR-1:0][PW-1:0] x_q, x_d, y_q, y_d;
    logic [N_SPR-1:0]         dx_q, dx_d, dy_q, dy_d;
    logic [N_SPR-1:0]         bounce_q, bounce_d;
    logic [11:0]              rgb_q, rgb_d;
    logic                     tick_q, tick_d;

    logic [N_SPR-1:0][PW+1:0] step_x, step_y;
    logic [PW-1:0]            spd, v;
    logic                     move;
    logic                     hit_any;
    logic [11:0]              hit_rgb;
    logic [PW-1:0]            pix_x, pix_y;

    // Returns {new_pos, new_dir_is_plus, reflected}; a reflection clamps to the wall.
    function automatic logic [PW+1:0] step_axis(input logic [PW-1:0] pos,
                                                input logic          fwd,
                                                input logic [PW-1:0] vel,
                                                input logic [PW-1:0] lim);
        logic [PW+1:0] r;
        if (fwd) begin
            if (pos + vel > lim) r = {lim, 1'b0, 1'b1};
            else                 r = {pos + vel, 1'b1, 1'b0};
        end else begin
            if (pos < vel)       r = {{PW{1'b0}}, 1'b1, 1'b1};
            else                 r = {pos - vel, 1'b0, 1'b0};
        end
        return r;
    endfunction

    always_comb begin
        tick_d = (i_y == TICK_ROW) && (i_x == 10'd0);
        spd    = {{(PW-3){1'b0}}, i_speed};
        v      = (spd > V_CAP) ? V_CAP : spd;
        move   = tick_d && !i_pause && (v != '0);

        x_d      = x_q;
        y_d      = y_q;
        dx_d     = dx_q;
        dy_d     = dy_q;
        bounce_d = '0;
        for (int k = 0; k < N_SPR; k++) begin
            step_x[k] = step_axis(x_q[k], dx_q[k], v, X_LIM);
            step_y[k] = step_axis(y_q[k], dy_q[k], v, Y_LIM);
            if (move) begin
                x_d[k]      = step_x[k][PW+1:2];
                dx_d[k]     = step_x[k][1];
                y_d[k]      = step_y[k][PW+1:2];
                dy_d[k]     = step_y[k][1];
                bounce_d[k] = step_x[k][0] | step_y[k][0];
            end
        end

        // Scan from the highest index down so the lowest-index sprite wins overlaps.
        pix_x   = {1'b0, i_x};
        pix_y   = {1'b0, i_y};
        hit_any = 1'b0;
        hit_rgb = BG_RGB;
        for (int k = N_SPR - 1; k >= 0; k--) begin
            if (pix_x >= x_q[k] && pix_x <= x_q[k] + SPR_LAST &&
                pix_y >= y_q[k] && pix_y <= y_q[k] + SPR_LAST) begin
                hit_any = 1'b1;
                hit_rgb = SPR_RGB[12*k +: 12];
            end
        end

        if (!i_video_on)  rgb_d = 12'h000;
        else if (hit_any) rgb_d = hit_rgb;
        else              rgb_d = BG_RGB;
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            for (int k = 0; k < N_SPR; k++) begin
                x_q[k]  <= PW'(16 + k * (SPR_SIZE + 16));
                y_q[k]  <= PW'(16 + k * 24);
                dx_q[k] <= ((k % 2) == 0);
                dy_q[k] <= 1'b1;
            end
            bounce_q <= '0;
            rgb_q    <= 12'h000;
            tick_q   <= 1'b0;
        end else begin
            x_q      <= x_d;
            y_q      <= y_d;
            dx_q     <= dx_d;
            dy_q     <= dy_d;
            bounce_q <= bounce_d;
            rgb_q    <= rgb_d;
            tick_q   <= tick_d;
        end
    end

    assign o_rgb        = rgb_q;
    assign o_frame_tick = tick_q;
    assign o_bounce     = bounce_q;

endmodule

// File: tb/tb_bouncing_sprite_engine.sv
// Randomised scoreboard bench for bouncing_sprite_engine with a plain-arithmetic
// reference model of sprite motion and pixel compositing.
module tb_bouncing_sprite_engine;

    localparam int N    = 4;
    localparam int SZ   = 32;
    localparam int LIMX = 639 - SZ + 1;
    localparam int LIMY = 479 - SZ + 1;

    logic          i_clk = 1'b0;
    logic          i_reset = 1'b1;
    logic          i_video_on = 1'b0;
    logic [9:0]    i_x = 10'd1;
    logic [9:0]    i_y = 10'd0;
    logic          i_pause = 1'b0;
    logic [2:0]    i_speed = 3'd0;
    logic [11:0]   o_rgb;
    logic          o_frame_tick;
    logic [N-1:0]  o_bounce;

    bouncing_sprite_engine dut (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_video_on   (i_video_on),
        .i_x          (i_x),
        .i_y          (i_y),
        .i_pause      (i_pause),
        .i_speed      (i_speed),
        .o_rgb        (o_rgb),
        .o_frame_tick (o_frame_tick),
        .o_bounce     (o_bounce)
    );

    always #5 i_clk = ~i_clk;

    int cyc = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    typedef struct {
        int           due;
        logic [11:0]  rgb;
        logic         tick;
        logic [N-1:0] bnc;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    bit   done    = 0;

    int          px[N], py[N], vx[N], vy[N];
    logic [11:0] colr[N] = '{12'hF00, 12'h0F0, 12'h00F, 12'hFF0};

    function automatic void model_reset();
        for (int k = 0; k < N; k++) begin
            px[k] = 16 + k * (SZ + 16);
            py[k] = 16 + k * 24;
            vx[k] = (k % 2 == 0) ? 1 : -1;
            vy[k] = 1;
        end
    endfunction

    function automatic logic [11:0] model_rgb(int x, int y, logic von);
        if (!von) return 12'h000;
        for (int k = 0; k < N; k++)
            if (x >= px[k] && x < px[k] + SZ && y >= py[k] && y < py[k] + SZ)
                return colr[k];
        return 12'h000;
    endfunction

    function automatic logic [N-1:0] model_tick(int speed, logic pause);
        int v, nx, ny;
        logic [N-1:0] m;
        m = '0;
        v = (speed > 7) ? 7 : speed;
        if (pause || v == 0) return m;
        for (int k = 0; k < N; k++) begin
            nx = px[k] + vx[k] * v;
            ny = py[k] + vy[k] * v;
            if (nx > LIMX)   begin px[k] = LIMX; vx[k] = -1; m[k] = 1'b1; end
            else if (nx < 0) begin px[k] = 0;    vx[k] = 1;  m[k] = 1'b1; end
            else              px[k] = nx;
            if (ny > LIMY)   begin py[k] = LIMY; vy[k] = -1; m[k] = 1'b1; end
            else if (ny < 0) begin py[k] = 0;    vy[k] = 1;  m[k] = 1'b1; end
            else              py[k] = ny;
        end
        return m;
    endfunction

    task automatic push(logic [11:0] r, logic t, logic [N-1:0] b);
        exp_t e;
        e.due  = cyc + 1;
        e.rgb  = r;
        e.tick = t;
        e.bnc  = b;
        sb.push_back(e);
    endtask

    task automatic drive(int x, int y, logic von);
        @(posedge i_clk); #1;
        if (y == 481 && x == 0) x = 1;
        i_x = 10'(x);
        i_y = 10'(y);
        i_video_on = von;
        push(model_rgb(x, y, von), 1'b0, '0);
    endtask

    task automatic tick_frame();
        logic [11:0]  r;
        logic [N-1:0] b;
        logic         von;
        @(posedge i_clk); #1;
        von = 1'($urandom_range(0, 1));
        i_x = 10'd0;
        i_y = 10'd481;
        i_video_on = von;
        r = model_rgb(0, 481, von);
        b = model_tick(int'(i_speed), i_pause);
        push(r, 1'b1, b);
    endtask

    task automatic probe();
        int k, x, y;
        k = $urandom_range(0, N - 1);
        case ($urandom_range(0, 5))
            0: x = px[k] - 1;
            1: x = px[k];
            2: x = px[k] + SZ - 1;
            3: x = px[k] + SZ;
            default: x = px[k] + int'($urandom_range(0, SZ - 1));
        endcase
        case ($urandom_range(0, 5))
            0: y = py[k] - 1;
            1: y = py[k];
            2: y = py[k] + SZ - 1;
            3: y = py[k] + SZ;
            default: y = py[k] + int'($urandom_range(0, SZ - 1));
        endcase
        if ($urandom_range(0, 7) == 0) begin
            x = int'($urandom_range(0, 799));
            y = int'($urandom_range(0, 479));
        end
        if (x < 0) x = 0;
        if (y < 0) y = 0;
        drive(x, y, $urandom_range(0, 9) != 0);
    endtask

    task automatic idle();
        @(posedge i_clk); #1;
        i_x = 10'd1;
        i_y = 10'd0;
        i_video_on = 1'b0;
    endtask

    task automatic reset_hold(int n);
        idle();
        @(negedge i_clk); #1;
        i_reset = 1'b1;
        model_reset();
        for (int i = 0; i < n; i++) begin
            @(posedge i_clk); #1;
            if (i == 1) begin i_x = 10'd0;  i_y = 10'd481; end
            else        begin i_x = 10'd16; i_y = 10'd16;  end
            i_video_on = 1'b1;
            push(12'h000, 1'b0, '0);
        end
        @(posedge i_clk); #1;
        i_reset = 1'b0;
        i_x = 10'd1;
        i_y = 10'd0;
        i_video_on = 1'b0;
    endtask

    // Monitor: compares whichever expectation falls due on this cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge i_clk);
            if (sb.size() > 0 && sb[0].due <= cyc) begin
                e = sb.pop_front();
                n_tests++;
                if (e.due != cyc || o_rgb !== e.rgb || o_frame_tick !== e.tick || o_bounce !== e.bnc) begin
                    n_fail++;
                    $display("FAIL cycle %0d (due %0d): rgb=%h tick=%b bounce=%b, expected rgb=%h tick=%b bounce=%b",
                             cyc, e.due, o_rgb, o_frame_tick, o_bounce, e.rgb, e.tick, e.bnc);
                end
            end
            if (done) begin
                n_tests++;
                if (sb.size() != 0) begin
                    n_fail++;
                    $display("FAIL drain: %0d expectations left, expected 0", sb.size());
                end
                $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
                $finish;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: run did not complete, %0d tests so far", n_tests);
        $fatal(1, "timeout");
    end

    initial begin
        reset_hold(3);

        drive(16, 16, 1'b1);
        drive(0, 0, 1'b1);
        drive(16, 16, 1'b0);
        drive(47, 47, 1'b1);
        drive(48, 16, 1'b1);

        i_speed = 3'd2;
        tick_frame();
        drive(18, 18, 1'b1);
        drive(17, 17, 1'b1);
        drive(62, 42, 1'b1);
        drive(61, 42, 1'b1);

        i_speed = 3'd7;
        repeat (12) begin
            tick_frame();
            repeat (4) probe();
        end

        i_pause = 1'b1;
        repeat (3) begin
            tick_frame();
            repeat (3) probe();
        end
        i_pause = 1'b0;
        i_speed = 3'd0;
        repeat (3) begin
            tick_frame();
            repeat (3) probe();
        end

        for (int f = 0; f < 400; f++) begin
            if (f == 200) begin
                reset_hold(4);
                drive(16, 16, 1'b1);
                drive(64, 40, 1'b1);
                drive(112, 64, 1'b1);
            end
            i_speed = 3'($urandom_range(0, 7));
            i_pause = ($urandom_range(0, 9) == 0);
            tick_frame();
            repeat (5) probe();
        end

        idle();
        done = 1;
    end

endmodule
